// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: default widths, opcodes, FSM states.
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int OP_W   = 6;
    localparam int SH_W   = 5;

    localparam int ALU_OP_ADD = 1;
    localparam int ALU_OP_SUB = 2;
    localparam int ALU_OP_AND = 3;
    localparam int ALU_OP_OR  = 4;
    localparam int ALU_OP_XOR = 5;
    localparam int ALU_OP_SHR = 6;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus between two requesters and the ALU arbiter.
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int OP_W   = alu_pkg::OP_W,
    parameter int SH_W   = alu_pkg::SH_W
);

    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*OP_W-1:0]   req_opcode;
    logic [2*DATA_W-1:0] req_a;
    logic [2*DATA_W-1:0] req_b;
    logic [2*SH_W-1:0]   req_shift;
    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_id;
    logic [DATA_W-1:0]   rsp_y;

    modport master (
        output req_valid, req_opcode, req_a, req_b, req_shift, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_y
    );

    modport slave (
        input  req_valid, req_opcode, req_a, req_b, req_shift, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_y
    );

endinterface

// File: rtl/alu.sv
// Combinational ALU; unknown opcodes pass operand A through unchanged.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int OP_W   = alu_pkg::OP_W,
    parameter int SH_W   = alu_pkg::SH_W
) (
    input  logic [OP_W-1:0]   opcode,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [SH_W-1:0]   shift,
    output logic [DATA_W-1:0] Y
);

    // Opcode decode; results are truncated to DATA_W with no flags.
    always_comb begin
        Y = A;
        case (opcode)
            OP_W'(ALU_OP_ADD): Y = (A << shift) + B;
            OP_W'(ALU_OP_SUB): Y = A - B;
            OP_W'(ALU_OP_AND): Y = A & B;
            OP_W'(ALU_OP_OR):  Y = A | B;
            OP_W'(ALU_OP_XOR): Y = A ^ B;
            OP_W'(ALU_OP_SHR): Y = A >> shift;
            default:           Y = A;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU.
// One operation in flight: IDLE (accept) -> EXEC (compute) -> RESP (hold result).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int OP_W   = alu_pkg::OP_W,
    parameter int SH_W   = alu_pkg::SH_W
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    state_t            state;
    logic              ptr;        // requester that wins the next tie
    logic              any_valid;
    logic              gnt_id;

    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [SH_W-1:0]   sel_sh;

    logic [OP_W-1:0]   op_r;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [SH_W-1:0]   sh_r;
    logic              id_r;

    logic              rsp_valid_r;
    logic              rsp_id_r;
    logic [DATA_W-1:0] rsp_y_r;
    logic [DATA_W-1:0] alu_y;

    // Grant selection: a lone requester always wins, a tie goes to ptr.
    always_comb begin
        any_valid = |bus.req_valid;
        gnt_id    = (&bus.req_valid) ? ptr : bus.req_valid[1];
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_op = bus.req_opcode[int'(gnt_id)*OP_W   +: OP_W];
        sel_a  = bus.req_a     [int'(gnt_id)*DATA_W +: DATA_W];
        sel_b  = bus.req_b     [int'(gnt_id)*DATA_W +: DATA_W];
        sel_sh = bus.req_shift [int'(gnt_id)*SH_W   +: SH_W];
    end

    // Ready is one-hot on the granted requester, only in IDLE and out of reset.
    always_comb begin
        bus.req_ready = '0;
        if (rst_n && state == IDLE && any_valid) begin
            bus.req_ready[gnt_id] = 1'b1;
        end
    end

    // Response outputs come straight from registers.
    always_comb begin
        bus.rsp_valid = rsp_valid_r;
        bus.rsp_id    = rsp_id_r;
        bus.rsp_y     = rsp_y_r;
    end

    alu #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W),
        .SH_W   (SH_W)
    ) u_alu (
        .opcode (op_r),
        .A      (a_r),
        .B      (b_r),
        .shift  (sh_r),
        .Y      (alu_y)
    );

    // Sequencer: capture on accept, register ALU result, hold until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            op_r        <= '0;
            a_r         <= '0;
            b_r         <= '0;
            sh_r        <= '0;
            id_r        <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_y_r     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        op_r  <= sel_op;
                        a_r   <= sel_a;
                        b_r   <= sel_b;
                        sh_r  <= sel_sh;
                        id_r  <= gnt_id;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_y_r     <= alu_y;
                    rsp_id_r    <= id_r;
                    rsp_valid_r <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        // ptr holds the tie winner, so the last owner is stored inverted;
                        // this keeps requester 0 first after reset.
                        ptr         <= ~rsp_id_r;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed + randomized bench for alu_arbiter with a transaction-level reference model.
module tb_alu_arbiter;

    localparam int DW = 16;
    localparam int OW = 6;
    localparam int SW = 5;

    typedef struct packed {
        logic [OW-1:0] op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [SW-1:0] s;
    } req_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fails  = 0;
    logic prio     = 1'b0;   // model: requester that should win the next tie

    alu_arbiter_if #(.DATA_W(DW), .OP_W(OW), .SH_W(SW)) bus ();

    alu_arbiter #(.DATA_W(DW), .OP_W(OW), .SH_W(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] alu_ref(input int op, input longint a, input longint b, input int s);
        longint r;
        case (op)
            1:       r = a * (longint'(1) << s) + b;
            2:       r = a - b;
            3:       r = a & b;
            4:       r = a | b;
            5:       r = a ^ b;
            6:       r = a / (longint'(1) << s);
            default: r = a;
        endcase
        return r[DW-1:0];
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        r.op = OW'($urandom_range(0, 9));
        r.a  = DW'($urandom);
        r.b  = DW'($urandom);
        r.s  = SW'($urandom);
        return r;
    endfunction

    function automatic req_t mk(input int op, input int a, input int b, input int s);
        req_t r;
        r.op = OW'(op);
        r.a  = DW'(a);
        r.b  = DW'(b);
        r.s  = SW'(s);
        return r;
    endfunction

    task automatic drive(input logic [1:0] v, input req_t r0, input req_t r1);
        bus.req_valid  = v;
        bus.req_opcode = {r1.op, r0.op};
        bus.req_a      = {r1.a, r0.a};
        bus.req_b      = {r1.b, r0.b};
        bus.req_shift  = {r1.s, r0.s};
    endtask

    // One complete transaction starting at a negedge with the DUT idle.
    task automatic do_op(input logic [1:0] v, input req_t r0, input req_t r1, input int bp,
                         output logic got_id, output logic [DW-1:0] got_y);
        logic          win;
        req_t          rw;
        logic [DW-1:0] ey;
        got_id = 1'b0;
        got_y  = '0;
        drive(v, r0, r1);
        #1;
        if (v == 2'b00) begin
            check("idle_ready", 32'(bus.req_ready), 32'd0);
            @(posedge clk); @(negedge clk);
            check("idle_stay", 32'(bus.rsp_valid), 32'd0);
            return;
        end
        win = (v == 2'b11) ? prio : v[1];
        rw  = win ? r1 : r0;
        ey  = alu_ref(int'(rw.op), longint'(rw.a), longint'(rw.b), int'(rw.s));
        check("grant", 32'(bus.req_ready), win ? 32'd2 : 32'd1);
        @(posedge clk); @(negedge clk);
        // Inputs after the accept edge must not affect the result.
        drive(2'($urandom), rnd_req(), rnd_req());
        #1;
        check("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("exec_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); @(negedge clk);
        check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rsp_id", 32'(bus.rsp_id), 32'(win));
        check("rsp_y", 32'(bus.rsp_y), 32'(ey));
        got_id = bus.rsp_id;
        got_y  = bus.rsp_y;
        for (int i = 0; i < bp; i++) begin
            bus.req_valid = 2'b11;
            bus.rsp_ready = 1'b0;
            @(posedge clk); @(negedge clk);
            check("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_id", 32'(bus.rsp_id), 32'(win));
            check("hold_y", 32'(bus.rsp_y), 32'(ey));
            check("hold_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = 2'b00;
        @(posedge clk); @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("rsp_drop", 32'(bus.rsp_valid), 32'd0);
        prio = ~win;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          id;
        logic [DW-1:0] y;
        req_t          z;
        z = mk(0, 0, 0, 0);

        // Reset state with requests pending.
        bus.rsp_ready = 1'b0;
        drive(2'b11, mk(1, 1, 1, 0), mk(1, 2, 0, 3));
        #2;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("rst_rsp_y", 32'(bus.rsp_y), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Tie after reset: r0 first, then r1.
        do_op(2'b11, mk(1, 1, 1, 0), mk(1, 2, 0, 3), 0, id, y);
        check("tie1_id", 32'(id), 32'd0);
        check("tie1_y", 32'(y), 32'd2);
        do_op(2'b11, mk(1, 1, 1, 0), mk(1, 2, 0, 3), 0, id, y);
        check("tie2_id", 32'(id), 32'd1);
        check("tie2_y", 32'(y), 32'd16);

        // Single ADD.
        do_op(2'b01, mk(1, 3, 5, 2), z, 0, id, y);
        check("add_id", 32'(id), 32'd0);
        check("add_y", 32'(y), 32'd17);

        // Wrap-around, lone requester 1.
        do_op(2'b10, z, mk(1, 'hFFFF, 2, 1), 0, id, y);
        check("wrap_id", 32'(id), 32'd1);
        check("wrap_y", 32'(y), 32'd0);

        // Backpressure for 5 cycles.
        do_op(2'b01, mk(1, 'h0123, 'h0456, 4), z, 5, id, y);
        check("bp_y", 32'(y), 32'h1686);

        // Reset during EXEC; the model's tie winner is now r1.
        drive(2'b11, mk(1, 7, 7, 0), mk(1, 9, 9, 0));
        #1;
        check("pre_rst_grant", 32'(bus.req_ready), 32'd2);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst_ready", 32'(bus.req_ready), 32'd0);
        check("midrst_y", 32'(bus.rsp_y), 32'd0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        prio  = 1'b0;
        bus.req_valid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            check("no_ghost_rsp", 32'(bus.rsp_valid), 32'd0);
        end

        // Fairness: alternation starting at r0 after reset.
        for (int i = 0; i < 8; i++) begin
            do_op(2'b11, rnd_req(), rnd_req(), 0, id, y);
            check("fair_id", 32'(id), 32'(i % 2));
        end
        for (int i = 0; i < 3; i++) begin
            do_op(2'b10, rnd_req(), rnd_req(), 0, id, y);
            check("solo_r1_id", 32'(id), 32'd1);
        end

        // Unknown opcode passes A through with normal sequencing.
        do_op(2'b01, mk(63, 'h1234, 'h00FF, 3), z, 1, id, y);
        check("unk_y", 32'(y), 32'h1234);

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            do_op(2'($urandom), rnd_req(), rnd_req(), int'($urandom_range(0, 3)), id, y);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
